// File: rtl/motor_step_decoder.sv
// motor_step_decoder: step/dir pulse decoder tracking position, step period and motion state.
// Optional glitch filter on the synchronised step input: define MOTOR_STEP_FILTER_EN.
//
// Parameters:
//   STALL_CYCLES  clk cycles without a step while moving before stall is flagged
//   MIN_PERIOD    smallest legal step period in clk cycles (shorter sets overspeed)
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous active-high reset
//   step_in       asynchronous step pulse from the pulse generator
//   dir           1 = increment, 0 = decrement, sampled with the detected edge
//   clear         synchronous clear of position, measurements and flags
//   target        position at which motion is complete
//   steps         current position (wraps modulo 2^32)
//   period        last measured step period in clk cycles
//   period_valid  one-cycle strobe when period updates
//   moving, arrived, stall, overspeed  status flags
module motor_step_decoder #(
  parameter int unsigned STALL_CYCLES = 1000,
  parameter int unsigned MIN_PERIOD   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_in,
  input  logic        dir,
  input  logic        clear,
  input  logic [31:0] target,
  output logic [31:0] steps,
  output logic [15:0] period,
  output logic        period_valid,
  output logic        moving,
  output logic        arrived,
  output logic        stall,
  output logic        overspeed
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    STALL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        step_edge;
  logic        seen;
  logic [15:0] period_cnt;
  logic [15:0] period_ld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= step_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef MOTOR_STEP_FILTER_EN
  // s2 must be high two cycles in a row; s4 marks it was low before that.
  logic s4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s4 <= 1'b0;
    end else begin
      s4 <= s3;
    end
  end

  assign step_edge = s2 & s3 & ~s4;
`else
  assign step_edge = s2 & ~s3;
`endif

  // The counter restarts at zero on an edge, so the span is cnt+1.
  assign period_ld = (&period_cnt) ? 16'hFFFF : period_cnt + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      steps        <= '0;
      period       <= '0;
      period_cnt   <= '0;
      period_valid <= 1'b0;
      overspeed    <= 1'b0;
      seen         <= 1'b0;
    end else if (clear) begin
      steps        <= '0;
      period       <= '0;
      period_cnt   <= '0;
      period_valid <= 1'b0;
      overspeed    <= 1'b0;
      seen         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (step_edge) begin
        steps      <= dir ? steps + 32'd1 : steps - 32'd1;
        period_cnt <= '0;
        seen       <= 1'b1;
        // The first edge has no predecessor to measure from.
        if (seen) begin
          period       <= period_ld;
          period_valid <= 1'b1;
          if (32'(period_ld) < MIN_PERIOD) begin
            overspeed <= 1'b1;
          end
        end
      end else if (~&period_cnt) begin
        period_cnt <= period_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    moving    = 1'b0;
    arrived   = 1'b0;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (step_edge) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        moving = 1'b1;
        if (!step_edge) begin
          if (steps == target) begin
            state_nxt = DONE;
          end else if (32'(period_cnt) >= STALL_CYCLES) begin
            state_nxt = STALL;
          end
        end
      end
      DONE: begin
        arrived = 1'b1;
        if (step_edge) begin
          state_nxt = RUN;
        end
      end
      STALL: begin
        stall = 1'b1;
        if (step_edge) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/motor_step_decoder.md
MOTOR_STEP_DECODER -- requirements
Module: motor_step_decoder

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 1000, meaning clk cycles without a detected step in RUN before STALL.
REQ-002 SHALL have parameter MIN_PERIOD, default 4, meaning the smallest legal step period in clk cycles.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port step_in  input  1  asynchronous step pulse from the motor pulse generator.
REQ-006 SHALL have port dir  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port clear  input  1  synchronous clear of position, measurements and flags.
REQ-008 SHALL have port target  input  32  position at which motion is complete.
REQ-009 SHALL have port steps  output  32  current position count.
REQ-010 SHALL have port period  output  16  last measured step period in clk cycles.
REQ-011 SHALL have port period_valid  output  1  one-cycle strobe when period updates.
REQ-012 SHALL have outputs moving, arrived, stall, overspeed, each 1 bit: status flags.

Function
REQ-013 SHALL synchronise step_in through two flops (s1, s2) plus history flop s3; detected edge = s2 & ~s3.
REQ-014 SHALL update steps on the 3rd rising clk edge after step_in rises, given setup is met.
REQ-015 SHALL sample dir in the detected-edge cycle; dir must be stable 3 cycles before step_in rises.
REQ-016 SHALL count steps modulo 2^32: 0xFFFFFFFF+1 -> 0 and 0-1 -> 0xFFFFFFFF.
REQ-017 SHALL run a 16-bit period_cnt: zeroed on each detected edge, otherwise incremented, saturating at 0xFFFF.
REQ-018 SHALL, on each detected edge except the first after reset/clear, load period <= min(period_cnt+1, 0xFFFF) and pulse period_valid for one cycle.
REQ-019 SHALL set overspeed (sticky until clear/reset) when a loaded period < MIN_PERIOD.
REQ-020 SHALL implement FSM states IDLE, RUN, DONE, STALL, with moving=1 only in RUN, arrived=1 only in DONE, stall=1 only in STALL.
REQ-021 SHALL, in IDLE, move to RUN on a detected edge, with the count applied in the same cycle.
REQ-022 SHALL, in RUN, move to DONE the cycle after registered steps == target; compare uses the registered steps.
REQ-023 SHALL, in RUN, move to STALL when period_cnt reaches STALL_CYCLES with no edge.
REQ-024 SHALL, in DONE or STALL, move to RUN on a detected edge, counting that step.
REQ-025 SHALL, on clear, zero steps, period and period_valid, drop all flags, and return to IDLE on the next clk edge.
REQ-026 SHALL give clear priority over a simultaneous detected edge; that edge is discarded.
REQ-027 SHALL not go to DONE when a step lands on target == steps while in IDLE; the first edge enters RUN, and DONE then follows the REQ-022 rule.

Reset
REQ-028 SHALL, on reset assertion, immediately set s1/s2/s3=0, steps=0, period=0, period_cnt=0, period_valid=0, overspeed=0, state IDLE (moving=arrived=stall=0).
REQ-029 SHALL resume edge detection on the first clk after reset deasserts; a step_in already high then counts as an edge.

Configuration
REQ-030 SHALL, with macro MOTOR_STEP_FILTER_EN defined, require s2 high for 2 consecutive cycles before an edge is accepted; one-cycle glitches are ignored and count latency becomes 4 cycles.
REQ-031 SHALL, without MOTOR_STEP_FILTER_EN, accept every s2 rising edge with the 3-cycle latency of REQ-014.

Verification
REQ-032 SHALL cover: 10 pulses, dir=1, period 8, target=10 -> steps=10, period=8 with 9 period_valid strobes, arrived=1 one cycle after the 10th count.
REQ-033 SHALL cover: steps=0, dir=0, 1 pulse -> steps=0xFFFFFFFF, moving=1.
REQ-034 SHALL cover: 3 pulses then silence for 1000 cycles, target=50 -> stall=1; next pulse -> stall=0, moving=1, steps=4.
REQ-035 SHALL cover: pulses every 2 cycles -> overspeed=1 that persists after the pulses stop until clear; clear coincident with an edge -> steps=0, state IDLE.
REQ-036 SHALL cover: with MOTOR_STEP_FILTER_EN, a 1-cycle step_in glitch -> steps unchanged; a 3-cycle pulse -> steps+1 after 4 cycles.
REQ-037 SHALL cover: reset asserted mid-RUN between clk edges -> all outputs 0 immediately, without waiting for clk.
